tenthirty_round_ctrl: RTL and testbench
=======================================

Name: tenthirty_round_ctrl

Overview:
- Round sequencer for the ten-point-half game. Owns the game FSM: player turn, dealer turn, compare, result, game over.
- Requests cards from the deck/random block over a req/vld handshake and accumulates both totals in half-point units.
- Decides each round's winner and keeps win counters.
- Sits between the button pulse generators and the seven-segment/LED display logic.

Parameters:
- ROUND_MAX, 4: rounds per game before GAME_OVER.
- MAX_CARDS, 5: cards per hand; reaching it ends that hand's turn.
- BUST_LIMIT, 21: highest legal total in half units (10.5 points).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- btn_m_pulse  in  1  one-cycle "draw" pulse
- btn_r_pulse  in  1  one-cycle "stand / next" pulse
- deal_req  out  1  card request to the deck, held until card_vld
- card_vld  in  1  card_code is valid this cycle; completes the request
- card_code  in  4  0 and 11..15 = half point; 1..10 = face value
- state  out  3  0 PLAYER, 1 P_DRAW, 2 DEALER, 3 D_DRAW, 4 COMPARE, 5 RESULT, 6 GAME_OVER
- player_total  out  6  player total, half units
- dealer_total  out  6  dealer total, half units
- pick_times  out  3  cards in the active hand
- card_wr  out  1  one-cycle strobe: card_code stored into slot pick_times-1
- round  out  3  current round, 1..ROUND_MAX
- winner  out  1  0 player, 1 dealer; valid in RESULT and GAME_OVER
- player_wins  out  3  rounds won by player
- dealer_wins  out  3  rounds won by dealer

Behaviour:
- Reset state: state=PLAYER, round=1; every other output 0 (deal_req 0, totals 0, pick_times 0, card_wr 0, winner 0, win counters 0).
- Card weight: code 1..10 → 2*code half units; code 0 or 11..15 → 1. Totals add with 6-bit saturation at 63; the largest reachable total is 20+4*20=100, so the clamp is required.
- PLAYER:
  - btn_r_pulse → DEALER. pick_times clears to 0; player_total is held.
  - btn_m_pulse (no btn_r) → P_DRAW, with deal_req=1 on the next cycle.
  - Both pulses in the same cycle: btn_r wins.
- P_DRAW:
  - deal_req stays 1 until card_vld. In the card_vld cycle: register the total, increment pick_times, pulse card_wr for 1 cycle, drop deal_req the following cycle.
  - Then go to DEALER (pick_times cleared) if the new total > BUST_LIMIT or pick_times == MAX_CARDS; otherwise return to PLAYER.
  - Buttons are ignored while in P_DRAW.
- DEALER / D_DRAW: same as PLAYER / P_DRAW but on dealer_total. btn_r, bust, or MAX_CARDS → COMPARE.
- COMPARE (1 cycle):
  - winner=0 if player_total ≤ BUST_LIMIT and (dealer_total > BUST_LIMIT or player_total > dealer_total); otherwise winner=1. Ties and a player bust both go to the dealer.
  - Increment the matching win counter, saturating at 7. Go to RESULT.
- RESULT:
  - Totals and winner are held for display; btn_m is ignored.
  - btn_r_pulse with round < ROUND_MAX: round+1, both totals, pick_times and winner clear to 0, go to PLAYER.
  - btn_r_pulse with round == ROUND_MAX: go to GAME_OVER.
- GAME_OVER: all outputs frozen; every button ignored until rst.
- A card_vld with no outstanding deal_req is ignored.
- rst asserted mid-draw drops deal_req immediately (async). A late card_vld after reset is ignored.
- Draw latency: button pulse → deal_req is 1 cycle; card_vld → updated total is 1 cycle.

Test Plan:
- Round 1: btn_m with code 10, btn_m with code 0, btn_r; dealer draws 8 then 2, btn_r → player_total=21, dealer_total=20, winner=0, player_wins=1.
- Player bust: btn_m ×3 with codes 2,2,7 → total 22 and auto-transition to DEALER with no btn_r. Dealer draws 0 then 6 (13), btn_r → winner=1.
- Five-card limit: player codes 0,0,1,5,0 (15) → auto-DEALER after the 5th card. Dealer codes 3,1,1,1,0 (13) → auto-COMPARE; winner=0; pick_times is 5 at the transition.
- Game end: after the round-4 RESULT, btn_r → GAME_OVER (state=6). Further btn_m/btn_r pulses leave all outputs unchanged; rst → state=0, round=1, wins=0.
- Handshake: hold card_vld low for 7 cycles → deal_req stays 1 and pick_times is unchanged. btn_m/btn_r pulses during the wait are ignored. A spurious card_vld in PLAYER causes no update.
- Simultaneous btn_m+btn_r in PLAYER → DEALER with no deal_req. Assert rst while deal_req=1 → deal_req=0 in the same cycle, then a late card_vld is ignored.

Source files
------------

// File: rtl/tenthirty_round_ctrl_if.sv
// Button, deck handshake and display-facing signals of the ten-point-half round controller.
// The master side drives buttons and cards; the slave side is the controller.
interface tenthirty_round_ctrl_if;
  logic       btn_m_pulse;
  logic       btn_r_pulse;
  logic       deal_req;
  logic       card_vld;
  logic [3:0] card_code;
  logic [2:0] state;
  logic [5:0] player_total;
  logic [5:0] dealer_total;
  logic [2:0] pick_times;
  logic       card_wr;
  logic [2:0] round;
  logic       winner;
  logic [2:0] player_wins;
  logic [2:0] dealer_wins;

  modport master (
    output btn_m_pulse, btn_r_pulse, card_vld, card_code,
    input  deal_req, state, player_total, dealer_total, pick_times, card_wr,
           round, winner, player_wins, dealer_wins
  );

  modport slave (
    input  btn_m_pulse, btn_r_pulse, card_vld, card_code,
    output deal_req, state, player_total, dealer_total, pick_times, card_wr,
           round, winner, player_wins, dealer_wins
  );
endinterface

// File: rtl/tenthirty_round_ctrl.sv
// Round sequencer for ten-point-half: player/dealer turns, card requests, compare, win counting.
// Totals are kept in half-point units; every output is driven straight from a register.
module tenthirty_round_ctrl #(
  parameter int ROUND_MAX  = 4,
  parameter int MAX_CARDS  = 5,
  parameter int BUST_LIMIT = 21
) (
  input  logic                 clk,
  input  logic                 rst,
  tenthirty_round_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    ST_PLAYER    = 3'd0,
    ST_P_DRAW    = 3'd1,
    ST_DEALER    = 3'd2,
    ST_D_DRAW    = 3'd3,
    ST_COMPARE   = 3'd4,
    ST_RESULT    = 3'd5,
    ST_GAME_OVER = 3'd6
  } state_t;

  localparam logic [5:0] BUST_C  = 6'(BUST_LIMIT);
  localparam logic [2:0] MAX_C   = 3'(MAX_CARDS);
  localparam logic [2:0] ROUND_C = 3'(ROUND_MAX);

  state_t     state_r, state_s;
  logic [5:0] player_total_r, player_total_s;
  logic [5:0] dealer_total_r, dealer_total_s;
  logic [2:0] pick_times_r, pick_times_s;
  logic [2:0] round_r, round_s;
  logic [2:0] player_wins_r, player_wins_s;
  logic [2:0] dealer_wins_r, dealer_wins_s;
  logic       winner_r, winner_s;
  logic       deal_req_r, deal_req_s;
  logic       card_wr_r, card_wr_s;
  logic [5:0] card_w_s;
  logic       p_win_s;

  function automatic logic [5:0] card_weight(input logic [3:0] code);
    if ((code >= 4'd1) && (code <= 4'd10)) begin
      return {1'b0, code, 1'b0};
    end else begin
      return 6'd1;
    end
  endfunction

  function automatic logic [5:0] sat_add(input logic [5:0] a, input logic [5:0] b);
    logic [6:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum[6]) begin
      return 6'd63;
    end else begin
      return sum[5:0];
    end
  endfunction

  function automatic logic [2:0] sat_inc(input logic [2:0] v);
    if (v == 3'd7) begin
      return v;
    end else begin
      return v + 3'd1;
    end
  endfunction

  // State and datapath registers; reset drops any outstanding card request at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r        <= ST_PLAYER;
      player_total_r <= 6'd0;
      dealer_total_r <= 6'd0;
      pick_times_r   <= 3'd0;
      round_r        <= 3'd1;
      player_wins_r  <= 3'd0;
      dealer_wins_r  <= 3'd0;
      winner_r       <= 1'b0;
      deal_req_r     <= 1'b0;
      card_wr_r      <= 1'b0;
    end else begin
      state_r        <= state_s;
      player_total_r <= player_total_s;
      dealer_total_r <= dealer_total_s;
      pick_times_r   <= pick_times_s;
      round_r        <= round_s;
      player_wins_r  <= player_wins_s;
      dealer_wins_r  <= dealer_wins_s;
      winner_r       <= winner_s;
      deal_req_r     <= deal_req_s;
      card_wr_r      <= card_wr_s;
    end
  end

  // Next-state and next-datapath logic for the game FSM.
  always_comb begin
    state_s        = state_r;
    player_total_s = player_total_r;
    dealer_total_s = dealer_total_r;
    pick_times_s   = pick_times_r;
    round_s        = round_r;
    player_wins_s  = player_wins_r;
    dealer_wins_s  = dealer_wins_r;
    winner_s       = winner_r;
    deal_req_s     = deal_req_r;
    card_wr_s      = 1'b0;
    card_w_s       = card_weight(bus.card_code);
    p_win_s        = (player_total_r <= BUST_C) &&
                     ((dealer_total_r > BUST_C) || (player_total_r > dealer_total_r));

    // A draw state spends one cycle waiting with deal_req high, then one cycle deciding.
    case (state_r)
      ST_PLAYER: begin
        if (bus.btn_r_pulse) begin
          state_s      = ST_DEALER;
          pick_times_s = 3'd0;
        end else if (bus.btn_m_pulse) begin
          state_s    = ST_P_DRAW;
          deal_req_s = 1'b1;
        end else begin
          state_s = ST_PLAYER;
        end
      end
      ST_P_DRAW: begin
        if (deal_req_r) begin
          if (bus.card_vld) begin
            player_total_s = sat_add(player_total_r, card_w_s);
            pick_times_s   = pick_times_r + 3'd1;
            card_wr_s      = 1'b1;
            deal_req_s     = 1'b0;
          end else begin
            deal_req_s = 1'b1;
          end
        end else if ((player_total_r > BUST_C) || (pick_times_r == MAX_C)) begin
          state_s      = ST_DEALER;
          pick_times_s = 3'd0;
        end else begin
          state_s = ST_PLAYER;
        end
      end
      ST_DEALER: begin
        if (bus.btn_r_pulse) begin
          state_s = ST_COMPARE;
        end else if (bus.btn_m_pulse) begin
          state_s    = ST_D_DRAW;
          deal_req_s = 1'b1;
        end else begin
          state_s = ST_DEALER;
        end
      end
      ST_D_DRAW: begin
        if (deal_req_r) begin
          if (bus.card_vld) begin
            dealer_total_s = sat_add(dealer_total_r, card_w_s);
            pick_times_s   = pick_times_r + 3'd1;
            card_wr_s      = 1'b1;
            deal_req_s     = 1'b0;
          end else begin
            deal_req_s = 1'b1;
          end
        end else if ((dealer_total_r > BUST_C) || (pick_times_r == MAX_C)) begin
          state_s = ST_COMPARE;
        end else begin
          state_s = ST_DEALER;
        end
      end
      ST_COMPARE: begin
        winner_s = ~p_win_s;
        if (p_win_s) begin
          player_wins_s = sat_inc(player_wins_r);
        end else begin
          dealer_wins_s = sat_inc(dealer_wins_r);
        end
        state_s = ST_RESULT;
      end
      ST_RESULT: begin
        if (bus.btn_r_pulse) begin
          if (round_r < ROUND_C) begin
            round_s        = round_r + 3'd1;
            player_total_s = 6'd0;
            dealer_total_s = 6'd0;
            pick_times_s   = 3'd0;
            winner_s       = 1'b0;
            state_s        = ST_PLAYER;
          end else begin
            state_s = ST_GAME_OVER;
          end
        end else begin
          state_s = ST_RESULT;
        end
      end
      ST_GAME_OVER: begin
        state_s = ST_GAME_OVER;
      end
      default: begin
        state_s    = ST_PLAYER;
        deal_req_s = 1'b0;
      end
    endcase
  end

  assign bus.state        = state_r;
  assign bus.player_total = player_total_r;
  assign bus.dealer_total = dealer_total_r;
  assign bus.pick_times   = pick_times_r;
  assign bus.round        = round_r;
  assign bus.winner       = winner_r;
  assign bus.player_wins  = player_wins_r;
  assign bus.dealer_wins  = dealer_wins_r;
  assign bus.deal_req     = deal_req_r;
  assign bus.card_wr      = card_wr_r;

endmodule

// File: tb/tb_tenthirty_round_ctrl.sv
// Scoreboard bench for tenthirty_round_ctrl: plays four rounds, then game over and reset cases.
module tb_tenthirty_round_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tenthirty_round_ctrl_if bus();

  tenthirty_round_ctrl #(.ROUND_MAX(4), .MAX_CARDS(5), .BUST_LIMIT(21)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  typedef struct packed { logic [5:0] total; logic [2:0] pick; } card_exp_t;
  typedef struct packed { logic win; logic [2:0] pw; logic [2:0] dw; } res_exp_t;

  card_exp_t card_q[$];
  res_exp_t  res_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  logic [5:0] p_model, d_model;
  logic [2:0] pick_model, pw_model, dw_model;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic press_r();
    bus.btn_r_pulse = 1'b1;
    cycle();
    bus.btn_r_pulse = 1'b0;
  endtask

  function automatic logic [5:0] weight(input logic [3:0] c);
    if (c >= 4'd1 && c <= 4'd10) return 6'(c) * 6'd2;
    else return 6'd1;
  endfunction

  // One draw: model update + scoreboard push, button, bounded wait for deal_req, card delivery.
  task automatic do_draw(input logic dealer, input logic [3:0] code,
                         output logic [5:0] obs_total, output logic [2:0] obs_pick, output logic obs_wr);
    logic [6:0] sum;
    card_exp_t e;
    sum = (dealer ? {1'b0, d_model} : {1'b0, p_model}) + {1'b0, weight(code)};
    if (sum > 7'd63) sum = 7'd63;
    if (dealer) d_model = sum[5:0];
    else p_model = sum[5:0];
    pick_model = pick_model + 3'd1;
    e.total = sum[5:0];
    e.pick  = pick_model;
    card_q.push_back(e);
    bus.btn_m_pulse = 1'b1;
    cycle();
    bus.btn_m_pulse = 1'b0;
    for (int i = 0; i < 16 && bus.deal_req !== 1'b1; i++) cycle();
    n_checks++;
    if (bus.deal_req !== 1'b1) begin
      n_fail++;
      $display("FAIL draw_req: deal_req=%b required 1", bus.deal_req);
    end
    bus.card_vld  = 1'b1;
    bus.card_code = code;
    cycle();
    bus.card_vld = 1'b0;
    obs_total = dealer ? bus.dealer_total : bus.player_total;
    obs_pick  = bus.pick_times;
    obs_wr    = bus.card_wr;
  endtask

  task automatic play_hand(input logic dealer, input logic [3:0] codes[$], input string tag);
    logic [5:0] t;
    logic [2:0] p, exp_state, exp_pick;
    logic w, ends;
    card_exp_t e;
    pick_model = 3'd0;
    foreach (codes[i]) begin
      do_draw(dealer, codes[i], t, p, w);
      e = card_q.pop_front();
      n_checks++;
      if (t !== e.total || p !== e.pick || w !== 1'b1) begin
        n_fail++;
        $display("FAIL %s_card%0d: total=%0d pick=%0d card_wr=%b, required total=%0d pick=%0d card_wr=1",
                 tag, i, t, p, w, e.total, e.pick);
      end
      cycle();
      ends      = (e.total > 6'd21) || (e.pick == 3'd5);
      exp_state = ends ? (dealer ? 3'd4 : 3'd2) : (dealer ? 3'd2 : 3'd0);
      exp_pick  = (ends && !dealer) ? 3'd0 : e.pick;
      n_checks++;
      if (bus.state !== exp_state || bus.pick_times !== exp_pick || bus.card_wr !== 1'b0) begin
        n_fail++;
        $display("FAIL %s_next%0d: state=%0d pick=%0d card_wr=%b, required state=%0d pick=%0d card_wr=0",
                 tag, i, bus.state, bus.pick_times, bus.card_wr, exp_state, exp_pick);
      end
    end
  endtask

  task automatic finish_round(input logic need_r, input string tag);
    res_exp_t e;
    logic pwin;
    pwin = (p_model <= 6'd21) && ((d_model > 6'd21) || (p_model > d_model));
    if (pwin) pw_model = pw_model + 3'd1;
    else dw_model = dw_model + 3'd1;
    e.win = ~pwin;
    e.pw  = pw_model;
    e.dw  = dw_model;
    res_q.push_back(e);
    if (need_r) press_r();
    n_checks++;
    if (bus.state !== 3'd4) begin
      n_fail++;
      $display("FAIL %s_compare: state=%0d required 4", tag, bus.state);
    end
    cycle();
    e = res_q.pop_front();
    n_checks++;
    if (bus.state !== 3'd5 || bus.winner !== e.win || bus.player_wins !== e.pw || bus.dealer_wins !== e.dw ||
        bus.player_total !== p_model || bus.dealer_total !== d_model) begin
      n_fail++;
      $display("FAIL %s_result: state=%0d winner=%b wins=%0d/%0d totals=%0d/%0d, required 5 %b %0d/%0d %0d/%0d",
               tag, bus.state, bus.winner, bus.player_wins, bus.dealer_wins, bus.player_total,
               bus.dealer_total, e.win, e.pw, e.dw, p_model, d_model);
    end
    // btn_m in RESULT must not start a draw
    bus.btn_m_pulse = 1'b1;
    cycle();
    bus.btn_m_pulse = 1'b0;
    n_checks++;
    if (bus.state !== 3'd5 || bus.deal_req !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_hold: state=%0d deal_req=%b required 5 0", tag, bus.state, bus.deal_req);
    end
  endtask

  task automatic next_round(input logic [2:0] exp_round);
    press_r();
    p_model = 6'd0;
    d_model = 6'd0;
    n_checks++;
    if (bus.state !== 3'd0 || bus.round !== exp_round || bus.player_total !== 6'd0 ||
        bus.dealer_total !== 6'd0 || bus.pick_times !== 3'd0 || bus.winner !== 1'b0) begin
      n_fail++;
      $display("FAIL next_round: state=%0d round=%0d totals=%0d/%0d pick=%0d winner=%b, required 0 %0d 0/0 0 0",
               bus.state, bus.round, bus.player_total, bus.dealer_total, bus.pick_times, bus.winner, exp_round);
    end
  endtask

  task automatic check_reset_values(input string tag);
    n_checks++;
    if (bus.state !== 3'd0 || bus.round !== 3'd1 || bus.deal_req !== 1'b0 || bus.player_total !== 6'd0 ||
        bus.dealer_total !== 6'd0 || bus.pick_times !== 3'd0 || bus.card_wr !== 1'b0 ||
        bus.winner !== 1'b0 || bus.player_wins !== 3'd0 || bus.dealer_wins !== 3'd0) begin
      n_fail++;
      $display("FAIL %s: state=%0d round=%0d req=%b totals=%0d/%0d pick=%0d wr=%b win=%b wins=%0d/%0d, required 0 1 0 0/0 0 0 0 0/0",
               tag, bus.state, bus.round, bus.deal_req, bus.player_total, bus.dealer_total, bus.pick_times,
               bus.card_wr, bus.winner, bus.player_wins, bus.dealer_wins);
    end
  endtask

  task automatic test_reset();
    bus.btn_m_pulse = 1'b0;
    bus.btn_r_pulse = 1'b0;
    bus.card_vld    = 1'b0;
    bus.card_code   = 4'd0;
    p_model = 6'd0; d_model = 6'd0; pick_model = 3'd0; pw_model = 3'd0; dw_model = 3'd0;
    rst = 1'b1;
    cycle();
    cycle();
    check_reset_values("reset");
    rst = 1'b0;
    cycle();
    check_reset_values("reset_release");
  endtask

  task automatic test_round1();
    play_hand(1'b0, '{4'd10, 4'd0}, "r1_player");
    press_r();
    n_checks++;
    if (bus.state !== 3'd2 || bus.pick_times !== 3'd0 || bus.player_total !== 6'd21) begin
      n_fail++;
      $display("FAIL r1_stand: state=%0d pick=%0d ptotal=%0d required 2 0 21", bus.state, bus.pick_times, bus.player_total);
    end
    play_hand(1'b1, '{4'd8, 4'd2}, "r1_dealer");
    finish_round(1'b1, "r1");
    next_round(3'd2);
  endtask

  task automatic test_player_bust();
    play_hand(1'b0, '{4'd2, 4'd2, 4'd7}, "bust_player");
    n_checks++;
    if (bus.player_total !== 6'd22) begin
      n_fail++;
      $display("FAIL bust_total: ptotal=%0d required 22", bus.player_total);
    end
    play_hand(1'b1, '{4'd0, 4'd6}, "bust_dealer");
    finish_round(1'b1, "r2");
    next_round(3'd3);
  endtask

  task automatic test_five_card();
    play_hand(1'b0, '{4'd0, 4'd0, 4'd1, 4'd5, 4'd0}, "five_player");
    play_hand(1'b1, '{4'd3, 4'd1, 4'd1, 4'd1, 4'd0}, "five_dealer");
    n_checks++;
    if (bus.pick_times !== 3'd5 || bus.dealer_total !== 6'd13 || bus.player_total !== 6'd15) begin
      n_fail++;
      $display("FAIL five_limit: pick=%0d totals=%0d/%0d required 5 15/13", bus.pick_times, bus.player_total, bus.dealer_total);
    end
    finish_round(1'b0, "r3");
    next_round(3'd4);
  endtask

  task automatic test_handshake();
    bus.btn_m_pulse = 1'b1;
    cycle();
    bus.btn_m_pulse = 1'b0;
    for (int i = 0; i < 7; i++) begin
      bus.btn_m_pulse = (i == 2);
      bus.btn_r_pulse = (i == 4);
      cycle();
      bus.btn_m_pulse = 1'b0;
      bus.btn_r_pulse = 1'b0;
      n_checks++;
      if (bus.deal_req !== 1'b1 || bus.pick_times !== 3'd0 || bus.state !== 3'd1) begin
        n_fail++;
        $display("FAIL wait%0d: req=%b pick=%0d state=%0d required 1 0 1", i, bus.deal_req, bus.pick_times, bus.state);
      end
    end
    bus.card_vld  = 1'b1;
    bus.card_code = 4'd10;
    cycle();
    bus.card_vld = 1'b0;
    p_model = 6'd20;
    n_checks++;
    if (bus.player_total !== 6'd20 || bus.pick_times !== 3'd1 || bus.card_wr !== 1'b1) begin
      n_fail++;
      $display("FAIL late_card: total=%0d pick=%0d wr=%b required 20 1 1", bus.player_total, bus.pick_times, bus.card_wr);
    end
    cycle();
    bus.card_vld  = 1'b1;
    bus.card_code = 4'd5;
    cycle();
    bus.card_vld = 1'b0;
    n_checks++;
    if (bus.player_total !== 6'd20 || bus.pick_times !== 3'd1 || bus.card_wr !== 1'b0 ||
        bus.state !== 3'd0 || bus.deal_req !== 1'b0) begin
      n_fail++;
      $display("FAIL spurious_vld: total=%0d pick=%0d wr=%b state=%0d req=%b required 20 1 0 0 0",
               bus.player_total, bus.pick_times, bus.card_wr, bus.state, bus.deal_req);
    end
  endtask

  task automatic test_simultaneous();
    bus.btn_m_pulse = 1'b1;
    bus.btn_r_pulse = 1'b1;
    cycle();
    bus.btn_m_pulse = 1'b0;
    bus.btn_r_pulse = 1'b0;
    n_checks++;
    if (bus.state !== 3'd2 || bus.deal_req !== 1'b0 || bus.pick_times !== 3'd0) begin
      n_fail++;
      $display("FAIL both_btn: state=%0d req=%b pick=%0d required 2 0 0", bus.state, bus.deal_req, bus.pick_times);
    end
    cycle();
    n_checks++;
    if (bus.deal_req !== 1'b0) begin
      n_fail++;
      $display("FAIL both_btn_req: req=%b required 0", bus.deal_req);
    end
  endtask

  task automatic test_game_end();
    finish_round(1'b1, "r4");
    press_r();
    for (int i = 0; i < 4; i++) begin
      bus.btn_m_pulse = (i == 0) || (i == 3);
      bus.btn_r_pulse = (i == 1) || (i == 3);
      bus.card_vld    = (i == 2);
      bus.card_code   = 4'd9;
      cycle();
      bus.btn_m_pulse = 1'b0;
      bus.btn_r_pulse = 1'b0;
      bus.card_vld    = 1'b0;
      n_checks++;
      if (bus.state !== 3'd6 || bus.round !== 3'd4 || bus.player_total !== p_model || bus.dealer_total !== d_model ||
          bus.winner !== 1'b0 || bus.player_wins !== pw_model || bus.dealer_wins !== dw_model ||
          bus.deal_req !== 1'b0 || bus.pick_times !== 3'd0 || bus.card_wr !== 1'b0) begin
        n_fail++;
        $display("FAIL game_over%0d: state=%0d round=%0d totals=%0d/%0d win=%b wins=%0d/%0d, required 6 4 %0d/%0d 0 %0d/%0d",
                 i, bus.state, bus.round, bus.player_total, bus.dealer_total, bus.winner, bus.player_wins,
                 bus.dealer_wins, p_model, d_model, pw_model, dw_model);
      end
    end
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    cycle();
    check_reset_values("after_game_rst");
  endtask

  task automatic test_reset_mid_draw();
    bus.btn_m_pulse = 1'b1;
    cycle();
    bus.btn_m_pulse = 1'b0;
    n_checks++;
    if (bus.deal_req !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_req: req=%b required 1", bus.deal_req);
    end
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus.deal_req !== 1'b0 || bus.state !== 3'd0) begin
      n_fail++;
      $display("FAIL async_rst: req=%b state=%0d required 0 0", bus.deal_req, bus.state);
    end
    cycle();
    rst = 1'b0;
    bus.card_vld  = 1'b1;
    bus.card_code = 4'd10;
    cycle();
    bus.card_vld = 1'b0;
    check_reset_values("late_vld");
  endtask

  initial begin
    test_reset();
    test_round1();
    test_player_bust();
    test_five_card();
    test_handshake();
    test_simultaneous();
    test_game_end();
    test_reset_mid_draw();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
